// File: rtl/risc_v_32_fetch.sv
// Instruction-fetch stage and IF/ID pipeline register for the RV32IM pipeline.
// Owns the PC, issues one outstanding imem request, and absorbs stalls and branch redirects.
module risc_v_32_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        StRst   = 2'd0,
        StFetch = 2'd1,
        StKill  = 2'd2,
        StHold  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        advance;
    logic        flush;
    logic [31:0] pc_plus4;

    assign advance  = pc_write & ifid_write;
    assign flush    = branch_taken;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        hold_inst_d  = hold_inst_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;

        unique case (state_q)
            StRst: begin
                state_d = StFetch;
            end

            StFetch: begin
                if (flush) begin
                    ifid_inst_d  = NOP_INST;
                    ifid_valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = branch_target;
                    end else begin
                        // Request is still pending: keep the address, squash it later.
                        redir_pc_d = branch_target;
                        state_d    = StKill;
                    end
                end else if (imem_ready) begin
                    if (advance) begin
                        ifid_pc_d    = pc_q;
                        ifid_inst_d  = imem_rdata;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_plus4;
                    end else begin
                        hold_inst_d = imem_rdata;
                        state_d     = StHold;
                    end
                end else if (ifid_write) begin
                    ifid_inst_d  = NOP_INST;
                    ifid_valid_d = 1'b0;
                end
            end

            StHold: begin
                if (flush) begin
                    pc_d         = branch_target;
                    hold_inst_d  = NOP_INST;
                    ifid_inst_d  = NOP_INST;
                    ifid_valid_d = 1'b0;
                    state_d      = StFetch;
                end else if (advance) begin
                    ifid_pc_d    = pc_q;
                    ifid_inst_d  = hold_inst_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                    state_d      = StFetch;
                end
            end

            StKill: begin
                if (flush) begin
                    redir_pc_d = branch_target;
                end
                if (flush || ifid_write) begin
                    ifid_inst_d  = NOP_INST;
                    ifid_valid_d = 1'b0;
                end
                if (imem_ready) begin
                    // The returned word belongs to the squashed address and is dropped.
                    pc_d    = flush ? branch_target : redir_pc_q;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StRst;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRst;
            pc_q         <= RESET_PC;
            redir_pc_q   <= 32'h0000_0000;
            hold_inst_q  <= NOP_INST;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            hold_inst_q  <= hold_inst_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Request is decoded from the async-reset state so it drops as soon as rst_n falls.
    assign imem_req   = (state_q == StFetch) || (state_q == StKill);
    assign imem_addr  = pc_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_risc_v_32_fetch.sv
// Directed bench for risc_v_32_fetch: reset, streaming, stall, redirects, wrap and async reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_risc_v_32_fetch;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        ifid_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_ifid_pc;
    logic [31:0] w_ifid_inst;
    logic        w_ifid_valid;

    int n_checks;
    int n_fail;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Memory word = its own address.
    assign imem_rdata = imem_addr;

    risc_v_32_fetch u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .ifid_pc      (ifid_pc),
        .ifid_inst    (ifid_inst),
        .ifid_valid   (ifid_valid)
    );

    risc_v_32_fetch #(
        .RESET_PC(32'hFFFF_FFFC)
    ) u_wrap (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_write     (1'b1),
        .ifid_write   (1'b1),
        .branch_taken (1'b0),
        .branch_target(32'h0000_0000),
        .imem_req     (w_req),
        .imem_addr    (w_addr),
        .imem_ready   (1'b1),
        .imem_rdata   (w_addr),
        .ifid_pc      (w_ifid_pc),
        .ifid_inst    (w_ifid_inst),
        .ifid_valid   (w_ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                              input logic valid);
        check({tag, "_pc"}, ifid_pc, pc);
        check({tag, "_inst"}, ifid_inst, inst);
        check({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    endtask

    task automatic check_fetch(input string tag, input logic req, input logic [31:0] addr);
        check({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic next;
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b1;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_ready    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_fetch("rst", 1'b0, 32'h0);
        check_ifid("rst", 32'h0, NOP, 1'b0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

        next; next;
        rst_n = 1'b1;                       // cycle 0 = RST
        next;                               // cycle 1
        check_fetch("c1", 1'b1, 32'h0);
        check("c1_valid", {31'd0, ifid_valid}, 32'd0);
        check("wrap_c1_addr", w_addr, 32'hFFFF_FFFC);
        next;                               // cycle 2
        check_ifid("c2", 32'h0, 32'h0, 1'b1);
        check("c2_addr", imem_addr, 32'h4);
        check("wrap_c2_addr", w_addr, 32'h0);
        check("wrap_c2_pc", w_ifid_pc, 32'hFFFF_FFFC);
        next;
        check_ifid("c3", 32'h4, 32'h4, 1'b1);
        next;
        check_ifid("c4", 32'h8, 32'h8, 1'b1);

        pc_write   = 1'b0;                  // two-cycle load-use stall
        ifid_write = 1'b0;
        next;
        check_ifid("stall1", 32'h8, 32'h8, 1'b1);
        check_fetch("stall1", 1'b0, 32'hC);
        next;
        check_ifid("stall2", 32'h8, 32'h8, 1'b1);
        check_fetch("stall2", 1'b0, 32'hC);
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        next;
        check_ifid("unstall", 32'hC, 32'hC, 1'b1);
        check_fetch("unstall", 1'b1, 32'h10);

        branch_taken  = 1'b1;               // zero-wait branch while fetching 0x10
        branch_target = 32'h100;
        next;
        branch_taken = 1'b0;
        check_ifid("br0", 32'hC, NOP, 1'b0);
        check_fetch("br0", 1'b1, 32'h100);
        next;
        check_ifid("br1", 32'h100, 32'h100, 1'b1);

        branch_taken  = 1'b1;               // steer to 0x20 for the wait-state case
        branch_target = 32'h20;
        next;
        check_fetch("to20", 1'b1, 32'h20);
        imem_ready    = 1'b0;
        branch_target = 32'h200;
        next;
        branch_taken = 1'b0;
        check_fetch("kill1", 1'b1, 32'h20);
        check_ifid("kill1", 32'h100, NOP, 1'b0);
        next;
        check_fetch("kill2", 1'b1, 32'h20);
        branch_taken  = 1'b1;               // later redirect during KILL wins
        branch_target = 32'h300;
        next;
        branch_taken = 1'b0;
        check_fetch("kill3", 1'b1, 32'h20);
        imem_ready = 1'b1;
        next;
        check_fetch("redir", 1'b1, 32'h300);
        check("redir_valid", {31'd0, ifid_valid}, 32'd0);
        next;
        check_ifid("redir1", 32'h300, 32'h300, 1'b1);

        pc_write      = 1'b0;               // flush overrides a concurrent stall
        ifid_write    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h400;
        next;
        branch_taken = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        check_ifid("sflush", 32'h300, NOP, 1'b0);
        check("sflush_addr", imem_addr, 32'h400);
        next;
        check_ifid("sflush1", 32'h400, 32'h400, 1'b1);

        pc_write   = 1'b0;                  // enter HOLD, then reset asynchronously
        ifid_write = 1'b0;
        next;
        check("hold_req", {31'd0, imem_req}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_fetch("arst_hold", 1'b0, 32'h0);
        check_ifid("arst_hold", 32'h0, NOP, 1'b0);
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        next;
        rst_n = 1'b1;
        next;
        check_fetch("rs1", 1'b1, 32'h0);
        next;
        check_ifid("rs1", 32'h0, 32'h0, 1'b1);

        imem_ready    = 1'b0;               // enter KILL, then reset asynchronously
        branch_taken  = 1'b1;
        branch_target = 32'h500;
        next;
        branch_taken = 1'b0;
        check_fetch("kill_pre", 1'b1, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check_fetch("arst_kill", 1'b0, 32'h0);
        check_ifid("arst_kill", 32'h0, NOP, 1'b0);
        next;
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        next;
        check_fetch("rs2", 1'b1, 32'h0);
        next;
        check_ifid("rs2a", 32'h0, 32'h0, 1'b1);
        next;
        check_ifid("rs2b", 32'h4, 32'h4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
